// File: rtl/turbo_bus_arb_pkg.sv
// Shared types and default sizing for the turbo-lane output bus arbiter.
package turbo_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_LANE       = 4;
  localparam int DEF_ST_PER_BUS     = 512;
  localparam int DEF_BEATS          = 2;
  localparam int DEF_GAP_CYCLES     = 38;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int LANE_W             = $clog2(DEF_NUM_LANE);
  localparam int CNT_W              = 8;

endpackage

// File: rtl/turbo_bus_arb_rr_pick.sv
// Round-robin first-set search: lowest offset from ptr (mod N) whose request bit is set.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] lane;

  // Scan from the far end so the smallest offset is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    lane  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      lane = W'((int'(ptr) + k) % N);
      if (req[lane]) begin
        found = 1'b1;
        idx   = lane;
      end
    end
  end

endmodule

// File: rtl/turbo_bus_arb.sv
// Grants one turbo lane at a time onto the shared output bus for a fixed-length
// packet, then holds the bus idle for an inter-packet gap before re-arbitrating.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ARB_IDLE  | no owner; round-robin pick among requesting lanes
//   ARB_GRANT | one lane owns the bus; forward its beats, watch for a stall
//   ARB_GAP   | packet finished or abandoned; bus quiet for GAP_CYCLES
module turbo_bus_arb
  import turbo_bus_pkg::*;
#(
  parameter int NUM_LANE              = DEF_NUM_LANE,
  parameter int ST_PER_BUS            = DEF_ST_PER_BUS,
  parameter int NUM_BUS_PER_TURBO_PKT = DEF_BEATS,
  parameter int GAP_CYCLES            = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES        = DEF_TIMEOUT_CYCLES,
  localparam int GID_W                = $clog2(NUM_LANE)
) (
  input  logic                           clk_bus,
  input  logic                           rst_n,
  input  logic [NUM_LANE-1:0]            lane_req,
  input  logic [NUM_LANE-1:0]            lane_en,
  input  logic [NUM_LANE*ST_PER_BUS-1:0] lane_data,
  output logic [NUM_LANE-1:0]            lane_ready,
  input  logic                           out_ready,
  output logic [ST_PER_BUS-1:0]          out_data,
  output logic                           out_en,
  output logic [GID_W-1:0]               grant_id,
  output logic                           busy,
  output logic                           err_timeout,
  output logic                           err_stray
);

  localparam int BEAT_W = $clog2(NUM_BUS_PER_TURBO_PKT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BUS_PER_TURBO_PKT - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [GID_W-1:0]  LAST_LANE = GID_W'(NUM_LANE - 1);

  arb_state_t              state_q, state_d;
  logic [GID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]        grant_id_q, grant_id_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]        to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic [ST_PER_BUS-1:0]   out_data_q, out_data_d;
  logic                    out_en_q, out_en_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    err_stray_q, err_stray_d;

  logic                    pick_found;
  logic [GID_W-1:0]        pick_idx;
  logic [GID_W-1:0]        next_ptr;
  logic [NUM_LANE-1:0]     other_en;
  logic                    pkt_end;
  logic [ST_PER_BUS-1:0]   lane_word [NUM_LANE];

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    assign lane_word[g] = lane_data[g*ST_PER_BUS +: ST_PER_BUS];
  end

  rr_pick #(
    .N (NUM_LANE),
    .W (GID_W)
  ) u_pick (
    .req   (lane_req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign next_ptr = (grant_id_q == LAST_LANE) ? '0 : grant_id_q + 1'b1;

  // Any beat that is not from the current owner is dropped and flagged.
  always_comb begin
    other_en = lane_en;
    if (state_q == ARB_GRANT) other_en[grant_id_q] = 1'b0;
  end

  always_comb begin
    lane_ready = '0;
    if (state_q == ARB_GRANT) lane_ready[grant_id_q] = out_ready;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    out_data_d    = out_data_q;
    out_en_d      = 1'b0;
    err_timeout_d = 1'b0;
    err_stray_d   = err_stray_q | (|other_en);
    pkt_end       = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          to_cnt_d   = '0;
          state_d    = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        // A beat on the stall threshold cycle takes priority over the timeout.
        if (lane_en[grant_id_q]) begin
          out_data_d = lane_word[grant_id_q];
          out_en_d   = 1'b1;
          to_cnt_d   = '0;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) pkt_end = 1'b1;
        end else begin
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            err_timeout_d = 1'b1;
            pkt_end       = 1'b1;
          end
        end
        if (pkt_end) begin
          rr_ptr_d  = next_ptr;
          gap_cnt_d = GAP_LOAD;
          state_d   = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
        end
      end

      ARB_GAP: begin
        if (gap_cnt_q == '0) state_d = ARB_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      beat_cnt_q    <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      out_data_q    <= '0;
      out_en_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      beat_cnt_q    <= beat_cnt_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      out_data_q    <= out_data_d;
      out_en_q      <= out_en_d;
      err_timeout_q <= err_timeout_d;
      err_stray_q   <= err_stray_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_en      = out_en_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != ARB_IDLE);
  assign err_timeout = err_timeout_q;
  assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_turbo_bus_arb.sv
// Randomised bench for turbo_bus_arb against a packet-level reference model
// (owner / beats remaining / stall count / gap remaining).
module tb_turbo_bus_arb;
  import turbo_bus_pkg::*;

  localparam int NL    = 4;
  localparam int SW    = 512;
  localparam int BEATS = 2;
  localparam int GAP   = 38;
  localparam int TMO   = 255;
  localparam int GW    = LANE_W;

  logic              clk_bus = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NL-1:0]     lane_req = '0;
  logic [NL-1:0]     lane_en  = '0;
  logic [NL*SW-1:0]  lane_data;
  logic [NL-1:0]     lane_ready;
  logic              out_ready = 1'b0;
  logic [SW-1:0]     out_data;
  logic              out_en;
  logic [GW-1:0]     grant_id;
  logic              busy, err_timeout, err_stray;
  logic [SW-1:0]     word [NL];

  int errors = 0;
  int checks = 0;

  always #5 clk_bus = ~clk_bus;

  for (genvar g = 0; g < NL; g++) begin : g_word
    assign lane_data[g*SW +: SW] = word[g];
  end

  turbo_bus_arb #(
    .NUM_LANE(NL), .ST_PER_BUS(SW), .NUM_BUS_PER_TURBO_PKT(BEATS),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .lane_req(lane_req), .lane_en(lane_en),
    .lane_data(lane_data), .lane_ready(lane_ready), .out_ready(out_ready),
    .out_data(out_data), .out_en(out_en), .grant_id(grant_id), .busy(busy),
    .err_timeout(err_timeout), .err_stray(err_stray)
  );

  // Reference model: who owns the bus, how much of its packet is left, how
  // long it has stalled, and how much of the quiet gap remains.
  bit            m_active;
  logic [GW-1:0] m_own, m_gid, m_ptr;
  int            m_left, m_stall, m_gap_left;
  logic [SW-1:0] m_data;
  bit            m_en, m_to, m_stray;

  function automatic void model_reset();
    m_active = 0; m_own = '0; m_gid = '0; m_ptr = '0;
    m_left = 0; m_stall = 0; m_gap_left = 0;
    m_data = '0; m_en = 0; m_to = 0; m_stray = 0;
  endfunction

  function automatic void end_packet();
    m_ptr      = GW'((int'(m_own) + 1) % NL);
    m_active   = 0;
    m_gap_left = GAP;
  endfunction

  function automatic void model_step();
    logic [GW-1:0] l;
    m_en = 0;
    m_to = 0;
    if (m_active) begin
      if ((lane_en & ~(NL'(1) << m_own)) != '0) m_stray = 1;
      if (lane_en[m_own]) begin
        m_en = 1; m_data = word[m_own]; m_stall = 0; m_left--;
        if (m_left == 0) end_packet();
      end else begin
        m_stall++;
        if (m_stall == TMO) begin m_to = 1; end_packet(); end
      end
    end else begin
      if (lane_en != '0) m_stray = 1;
      if (m_gap_left > 0) m_gap_left--;
      else begin
        for (int j = 0; j < NL; j++) begin
          l = GW'((int'(m_ptr) + j) % NL);
          if (!m_active && lane_req[l]) begin
            m_active = 1; m_own = l; m_gid = l; m_left = BEATS; m_stall = 0;
          end
        end
      end
    end
  endfunction

  function automatic logic [NL-1:0] exp_ready();
    return (m_active && out_ready) ? (NL'(1) << m_own) : '0;
  endfunction

  function automatic bit exp_busy();
    return m_active || (m_gap_left > 0);
  endfunction

  function automatic logic [SW-1:0] rand_word();
    logic [SW-1:0] r = '0;
    for (int i = 0; i < SW / 32; i++) r = {r[SW-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic randomize_words();
    for (int i = 0; i < NL; i++) word[i] = rand_word();
  endtask

  task automatic tick();
    @(posedge clk_bus);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    lane_req = '0; lane_en = '0; out_ready = 1'b0;
    for (int i = 0; i < NL; i++) word[i] = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk_bus);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (out_en !== 1'b0)      begin errors++; $display("FAIL reset_out_en got=%0b exp=0", out_en); end
    if (out_data !== '0)      begin errors++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    if (grant_id !== '0)      begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (lane_ready !== '0)    begin errors++; $display("FAIL reset_lane_ready got=%0b exp=0", lane_ready); end
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout got=%0b exp=0", err_timeout); end
    if (err_stray !== 1'b0)   begin errors++; $display("FAIL reset_err_stray got=%0b exp=0", err_stray); end
  endtask

  task automatic test_single();
    int quiet = 0, gap_checks = 0;
    bit seen = 0;
    do_reset();
    lane_req = 4'b0100; out_ready = 1'b1;
    for (int c = 0; c < 90; c++) begin
      randomize_words();
      lane_en = exp_ready();
      tick();
      checks += 4;
      if (out_en !== m_en)     begin errors++; $display("FAIL single_out_en cyc=%0d got=%0b exp=%0b", c, out_en, m_en); end
      if (out_data !== m_data) begin errors++; $display("FAIL single_out_data cyc=%0d got=%0h exp=%0h", c, out_data, m_data); end
      if (grant_id !== m_gid)  begin errors++; $display("FAIL single_grant_id cyc=%0d got=%0d exp=%0d", c, grant_id, m_gid); end
      if (busy !== exp_busy()) begin errors++; $display("FAIL single_busy cyc=%0d got=%0b exp=%0b", c, busy, exp_busy()); end
      if (out_en === 1'b1) begin
        checks++;
        if (grant_id !== GW'(2)) begin errors++; $display("FAIL single_lane cyc=%0d got=%0d exp=2", c, grant_id); end
        if (quiet != 0) begin
          checks++; gap_checks++;
          if (quiet != GAP + 1) begin errors++; $display("FAIL single_gap got=%0d exp=%0d", quiet, GAP + 1); end
        end
        quiet = 0; seen = 1;
      end else if (seen) quiet++;
    end
    checks++;
    if (gap_checks == 0) begin errors++; $display("FAIL single_gap_seen got=0 exp=nonzero"); end
  endtask

  task automatic test_round_robin();
    int beats = 0;
    do_reset();
    lane_req = 4'b1111;
    for (int c = 0; c < 250; c++) begin
      randomize_words();
      out_ready = ($urandom_range(0, 3) != 0);
      lane_en = exp_ready();
      #1;
      checks++;
      if (lane_ready !== exp_ready()) begin errors++; $display("FAIL rr_lane_ready cyc=%0d got=%0b exp=%0b", c, lane_ready, exp_ready()); end
      tick();
      checks += 3;
      if (out_en !== m_en)     begin errors++; $display("FAIL rr_out_en cyc=%0d got=%0b exp=%0b", c, out_en, m_en); end
      if (out_data !== m_data) begin errors++; $display("FAIL rr_out_data cyc=%0d got=%0h exp=%0h", c, out_data, m_data); end
      if (grant_id !== m_gid)  begin errors++; $display("FAIL rr_grant_id cyc=%0d got=%0d exp=%0d", c, grant_id, m_gid); end
      if (out_en === 1'b1) begin
        if (beats < BEATS * 5) begin
          checks++;
          if (grant_id !== GW'((beats / BEATS) % NL))
            begin errors++; $display("FAIL rr_order beat=%0d got=%0d exp=%0d", beats, grant_id, (beats / BEATS) % NL); end
        end
        beats++;
      end
    end
    checks++;
    if (beats < BEATS * 5) begin errors++; $display("FAIL rr_beat_count got=%0d exp>=%0d", beats, BEATS * 5); end
  endtask

  task automatic test_ready_stall();
    logic [SW-1:0] a, b;
    bit got = 0;
    do_reset();
    lane_req = 4'b0001; out_ready = 1'b1;
    for (int c = 0; c < 5 && !got; c++) begin tick(); got = m_active; end
    checks++;
    if (!got) begin errors++; $display("FAIL stall_grant_wait got=none exp=lane0"); end
    a = rand_word(); b = rand_word();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      word[0] = a; lane_en = exp_ready();
      #1;
      checks++;
      if (lane_ready !== '0) begin errors++; $display("FAIL stall_lane_ready cyc=%0d got=%0b exp=0", c, lane_ready); end
      tick();
      checks++;
      if (out_en !== 1'b0) begin errors++; $display("FAIL stall_out_en cyc=%0d got=%0b exp=0", c, out_en); end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      word[0] = (k == 0) ? a : b;
      lane_en = exp_ready();
      #1;
      checks++;
      if (lane_ready !== 4'b0001) begin errors++; $display("FAIL resume_lane_ready beat=%0d got=%0b exp=0001", k, lane_ready); end
      tick();
      checks += 2;
      if (out_en !== 1'b1) begin errors++; $display("FAIL resume_out_en beat=%0d got=%0b exp=1", k, out_en); end
      if (out_data !== word[0]) begin errors++; $display("FAIL resume_out_data beat=%0d got=%0h exp=%0h", k, out_data, word[0]); end
    end
    lane_en = '0;
    tick();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL resume_gap_busy got=%0b exp=1", busy); end
    if (lane_ready !== '0) begin errors++; $display("FAIL resume_gap_ready got=%0b exp=0", lane_ready); end
  endtask

  task automatic test_timeout();
    int pulses = 0, pulse_at = -1, l2_beats = 0;
    do_reset();
    lane_req = 4'b0110; out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      randomize_words();
      lane_en = (m_active && m_own == GW'(2)) ? 4'b0100 : 4'b0000;
      tick();
      checks += 4;
      if (err_timeout !== m_to) begin errors++; $display("FAIL to_pulse cyc=%0d got=%0b exp=%0b", c, err_timeout, m_to); end
      if (grant_id !== m_gid)   begin errors++; $display("FAIL to_grant_id cyc=%0d got=%0d exp=%0d", c, grant_id, m_gid); end
      if (busy !== exp_busy())  begin errors++; $display("FAIL to_busy cyc=%0d got=%0b exp=%0b", c, busy, exp_busy()); end
      if (out_en !== m_en)      begin errors++; $display("FAIL to_out_en cyc=%0d got=%0b exp=%0b", c, out_en, m_en); end
      if (err_timeout === 1'b1) begin pulses++; pulse_at = c; end
      if (out_en === 1'b1 && grant_id === GW'(2)) l2_beats++;
    end
    checks += 3;
    if (pulses != 1)     begin errors++; $display("FAIL to_pulse_count got=%0d exp=1", pulses); end
    if (pulse_at != TMO) begin errors++; $display("FAIL to_pulse_cycle got=%0d exp=%0d", pulse_at, TMO); end
    if (l2_beats != BEATS) begin errors++; $display("FAIL to_next_lane2_beats got=%0d exp=%0d", l2_beats, BEATS); end
  endtask

  task automatic test_stray();
    logic [SW-1:0] pat = '1;
    do_reset();
    lane_req = 4'b0001; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      randomize_words();
      word[3] = pat;
      lane_en = exp_ready() | ((m_active && m_own == GW'(0)) ? 4'b1000 : 4'b0000);
      tick();
      checks += 3;
      if (out_data === pat)      begin errors++; $display("FAIL stray_leak cyc=%0d got=%0h exp=not_lane3", c, out_data); end
      if (err_stray !== m_stray) begin errors++; $display("FAIL stray_flag cyc=%0d got=%0b exp=%0b", c, err_stray, m_stray); end
      if (out_data !== m_data)   begin errors++; $display("FAIL stray_out_data cyc=%0d got=%0h exp=%0h", c, out_data, m_data); end
    end
    checks++;
    if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_sticky got=%0b exp=1", err_stray); end
    do_reset();
    checks++;
    if (err_stray !== 1'b0) begin errors++; $display("FAIL stray_clear got=%0b exp=0", err_stray); end
  endtask

  task automatic test_async_reset();
    bit got = 0;
    do_reset();
    lane_req = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 6 && !got; c++) begin
      randomize_words(); lane_en = exp_ready(); tick(); got = m_en;
    end
    checks++;
    if (out_en !== 1'b1 || !got) begin errors++; $display("FAIL areset_first_beat got=%0b exp=1", out_en); end
    #2 lane_en = '0; rst_n = 1'b0;
    #1;
    checks += 6;
    if (out_en !== 1'b0)   begin errors++; $display("FAIL areset_out_en got=%0b exp=0", out_en); end
    if (out_data !== '0)   begin errors++; $display("FAIL areset_out_data got=%0h exp=0", out_data); end
    if (grant_id !== '0)   begin errors++; $display("FAIL areset_grant_id got=%0d exp=0", grant_id); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL areset_busy got=%0b exp=0", busy); end
    if (lane_ready !== '0) begin errors++; $display("FAIL areset_lane_ready got=%0b exp=0", lane_ready); end
    if (err_stray !== 1'b0) begin errors++; $display("FAIL areset_err_stray got=%0b exp=0", err_stray); end
    #1 rst_n = 1'b1;
    model_reset();
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      randomize_words(); lane_en = exp_ready(); tick();
      checks++;
      if (grant_id !== m_gid) begin errors++; $display("FAIL areset_regrant cyc=%0d got=%0d exp=%0d", c, grant_id, m_gid); end
      if (out_en === 1'b1) begin
        got = 1; checks++;
        if (grant_id !== '0) begin errors++; $display("FAIL areset_restart_lane got=%0d exp=0", grant_id); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL areset_restart_wait got=none exp=beat"); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      randomize_words();
      if ($urandom_range(0, 7) == 0) lane_req = NL'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      lane_en = '0;
      if (m_active && $urandom_range(0, 9) < 8) lane_en = NL'(1) << m_own;
      if (c > 1000 && $urandom_range(0, 49) == 0) lane_en = lane_en | NL'($urandom);
      #1;
      checks++;
      if (lane_ready !== exp_ready()) begin errors++; $display("FAIL rnd_lane_ready cyc=%0d got=%0b exp=%0b", c, lane_ready, exp_ready()); end
      tick();
      checks += 6;
      if (out_en !== m_en)        begin errors++; $display("FAIL rnd_out_en cyc=%0d got=%0b exp=%0b", c, out_en, m_en); end
      if (out_data !== m_data)    begin errors++; $display("FAIL rnd_out_data cyc=%0d got=%0h exp=%0h", c, out_data, m_data); end
      if (grant_id !== m_gid)     begin errors++; $display("FAIL rnd_grant_id cyc=%0d got=%0d exp=%0d", c, grant_id, m_gid); end
      if (busy !== exp_busy())    begin errors++; $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", c, busy, exp_busy()); end
      if (err_timeout !== m_to)   begin errors++; $display("FAIL rnd_err_timeout cyc=%0d got=%0b exp=%0b", c, err_timeout, m_to); end
      if (err_stray !== m_stray)  begin errors++; $display("FAIL rnd_err_stray cyc=%0d got=%0b exp=%0b", c, err_stray, m_stray); end
    end
  endtask

  initial begin
    for (int i = 0; i < NL; i++) word[i] = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_ready_stall();
    test_timeout();
    test_stray();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
